adex_neuron_array: RTL and testbench
====================================

// Module: adex_neuron_array
// PURPOSE
//  Time-multiplexed array of N adaptive exponential integrate-and-fire (AdEx) neurons.
//  Adds per-channel adaptation current, refractory period, saturating arithmetic and AER spike output.
//  Sits behind the tt_um top; ui_in and uio pins drive per-channel current and monitor select.
//  One neuron is updated per enabled clock, in round-robin order 0..N-1.
// PARAMETERS
//  WIDTH        8    membrane (v), adaptation (w) and current width, unsigned
//  N_NEURONS    4    channel count, >=2; CH_W = $clog2(N_NEURONS)
//  LEAK_SHIFT   3    leak term = v >> LEAK_SHIFT
//  V_T          150  exponential knee; above it, extra drive = v - V_T
//  THRESH       200  spike when v_calc >= THRESH
//  V_RESET      20   membrane value after spike and during refractory
//  B_INC        16   w increment on spike
//  ADAPT_SHIFT  4    w decay = w >> ADAPT_SHIFT per update
//  REFRAC       2    refractory length, in own-channel update slots (0 = none)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               async active-low reset
//  en         in   1               1: advance round-robin; 0: freeze all state
//  current    in   N*WIDTH         packed input currents; channel k = [k*WIDTH +: WIDTH]
//  mon_sel    in   CH_W            channel shown on state/w_out/count_out
//  spike      out  N               one-clock pulse per channel that fired
//  aer_valid  out  1               one-clock pulse with aer_addr when any spike fires
//  aer_addr   out  CH_W            index of the firing channel
//  state      out  WIDTH           v[mon_sel], combinational read of register file
//  w_out      out  WIDTH           w[mon_sel]
//  count_out  out  8               spike count of mon_sel (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): all v, w, refractory counters, ch_idx = 0; spike, aer_valid, aer_addr = 0.
//  - ch_idx increments on every clk with en=1, wraps N-1 -> 0. Only channel ch_idx updates.
//  - Update, in WIDTH+3-bit signed arithmetic, old values throughout:
//      exp    = (v >= V_T) ? v - V_T : 0
//      v_calc = v - (v >> LEAK_SHIFT) + I - w + exp; clamp to [0, 2^WIDTH-1]
//  - Per-channel states: INTEGRATE, REFRACTORY.
//  - INTEGRATE, v_calc >= THRESH:
//      v <= V_RESET; refrac cnt <= REFRAC.
//      Enter REFRACTORY if REFRAC > 0; otherwise stay in INTEGRATE.
//      spike[ch], aer_valid pulse high for the following clock; aer_addr <= ch.
//  - INTEGRATE, v_calc < THRESH: v <= v_calc.
//  - REFRACTORY: I ignored; v held at V_RESET; cnt decrements per own slot.
//      Back to INTEGRATE on the slot where cnt reaches 0; integration resumes next slot.
//  - w, every own slot: w <= sat(w - (w >> ADAPT_SHIFT) + (fired ? B_INC : 0)).
//  - At most one spike per clock, so aer needs no arbitration. spike/aer deassert while en=0.
//  - Registered-output latency: spike visible 1 clk after the update edge.
//    state reflects the new v on that same clk.
//  - Reset mid-update aborts immediately; no partial write survives.
// CONFIGURATION
//  ADEX_SPIKE_COUNT_EN defined:
//    per-channel 8-bit saturating spike counters (stick at 255), cleared by rst_n.
//    count_out = cnt[mon_sel].
//  Undefined: no counter flops; count_out tied 8'd0.
// TESTING (defaults, en=1)
//  1 rst_n=0 mid-run -> spike=0, aer_valid=0, state=0, w_out=0 immediately, no clk needed.
//  2 all current=0 for 64 clks -> every v and w stays 0; no spikes.
//  3 ch0=40, others 0 -> v0 after updates: 40,75,106,133,157,185.
//    7th ch0 update fires (v_calc=237): spike[0]=1, aer_addr=0, v0=20, w0=16.
//  4 after test 3 -> next 2 ch0 slots hold v0=20, w0 decays 16->15->15.
//    Integration resumes on the 3rd slot: v0 = 20-2+40-15 = 43.
//  5 ch2=255 -> fires on first ch2 update (clk 3 after reset).
//    No other spike[]; with mon_sel=2, w_out=16.
//  6 ADEX_SPIKE_COUNT_EN, ch1=255 for 4000 clks -> count_out (mon_sel=1) saturates at 255.
//    Without the macro, count_out=0 throughout.

Source files
------------

// File: rtl/adex_neuron_array.sv
// rtl/adex_neuron_array.sv - time-multiplexed AdEx neuron array with refractory period and AER spike output
// Optional per-channel spike counters are enabled by defining ADEX_SPIKE_COUNT_EN.
module adex_neuron_array #(
  parameter int WIDTH       = 8,
  parameter int N_NEURONS   = 4,
  parameter int LEAK_SHIFT  = 3,
  parameter int V_T         = 150,
  parameter int THRESH      = 200,
  parameter int V_RESET     = 20,
  parameter int B_INC       = 16,
  parameter int ADAPT_SHIFT = 4,
  parameter int REFRAC      = 2,
  localparam int CH_W       = $clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [N_NEURONS*WIDTH-1:0] current_i,
  input  logic [CH_W-1:0]            mon_sel_i,
  output logic [N_NEURONS-1:0]       spike_o,
  output logic                       aer_valid_o,
  output logic [CH_W-1:0]            aer_addr_o,
  output logic [WIDTH-1:0]           state_o,
  output logic [WIDTH-1:0]           w_out_o,
  output logic [7:0]                 count_out_o
);

  typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} st_e;

  localparam int AW   = WIDTH + 3;
  localparam int WP1  = WIDTH + 1;
  localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [WIDTH-1:0]     v_q  [N_NEURONS];
  logic [WIDTH-1:0]     w_q  [N_NEURONS];
  logic [RC_W-1:0]      rc_q [N_NEURONS];
  st_e                  st_q [N_NEURONS];
  logic [CH_W-1:0]      ch_q;
  logic [N_NEURONS-1:0] spike_q;
  logic                 aer_valid_q;
  logic [CH_W-1:0]      aer_addr_q;

  logic [WIDTH-1:0] v_cur, w_cur, i_cur, v_calc, v_d, w_d, w_dec;
  logic [RC_W-1:0]  rc_cur, rc_d;
  st_e              st_cur, st_d;
  logic [AW-1:0]    exp_t, sum;
  logic [WIDTH:0]   w_sum;
  logic             fire;

  assign v_cur  = v_q[ch_q];
  assign w_cur  = w_q[ch_q];
  assign rc_cur = rc_q[ch_q];
  assign st_cur = st_q[ch_q];
  assign i_cur  = current_i[ch_q*WIDTH +: WIDTH];

  // Unsigned operands widened by 3 bits so the sum's MSB acts as the sign for clamping.
  always_comb begin
    exp_t = (v_cur >= WIDTH'(V_T)) ? (AW'(v_cur) - AW'(V_T)) : '0;
    sum   = AW'(v_cur) - AW'(v_cur >> LEAK_SHIFT) + AW'(i_cur) - AW'(w_cur) + exp_t;
    if (sum[AW-1])             v_calc = '0;
    else if (|sum[AW-2:WIDTH]) v_calc = '1;
    else                       v_calc = sum[WIDTH-1:0];
  end

  always_comb begin
    st_d = st_cur;
    v_d  = v_cur;
    rc_d = rc_cur;
    fire = 1'b0;
    case (st_cur)
      ST_INTEGRATE: begin
        if (v_calc >= WIDTH'(THRESH)) begin
          fire = 1'b1;
          v_d  = WIDTH'(V_RESET);
          rc_d = RC_W'(REFRAC);
          st_d = (REFRAC > 0) ? ST_REFRACTORY : ST_INTEGRATE;
        end else begin
          v_d = v_calc;
        end
      end
      ST_REFRACTORY: begin
        v_d  = WIDTH'(V_RESET);
        rc_d = rc_cur - RC_W'(1);
        if (rc_cur <= RC_W'(1)) st_d = ST_INTEGRATE;
      end
      default: st_d = ST_INTEGRATE;
    endcase
  end

  always_comb begin
    w_dec = w_cur - (w_cur >> ADAPT_SHIFT);
    w_sum = {1'b0, w_dec} + (fire ? WP1'(B_INC) : '0);
    w_d   = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]  <= '0;
        w_q[k]  <= '0;
        rc_q[k] <= '0;
        st_q[k] <= ST_INTEGRATE;
      end
      ch_q        <= '0;
      spike_q     <= '0;
      aer_valid_q <= 1'b0;
      aer_addr_q  <= '0;
    end else if (en_i) begin
      v_q[ch_q]   <= v_d;
      w_q[ch_q]   <= w_d;
      rc_q[ch_q]  <= rc_d;
      st_q[ch_q]  <= st_d;
      ch_q        <= (ch_q == CH_W'(N_NEURONS - 1)) ? '0 : ch_q + CH_W'(1);
      spike_q     <= fire ? (N_NEURONS'(1) << ch_q) : '0;
      aer_valid_q <= fire;
      if (fire) aer_addr_q <= ch_q;
    end else begin
      spike_q     <= '0;
      aer_valid_q <= 1'b0;
    end
  end

  assign spike_o     = spike_q;
  assign aer_valid_o = aer_valid_q;
  assign aer_addr_o  = aer_addr_q;
  assign state_o     = v_q[mon_sel_i];
  assign w_out_o     = w_q[mon_sel_i];

`ifdef ADEX_SPIKE_COUNT_EN
  logic [7:0] cnt_q [N_NEURONS];

  // Counters stick at 255 rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) cnt_q[k] <= '0;
    end else if (en_i && fire && (cnt_q[ch_q] != 8'hFF)) begin
      cnt_q[ch_q] <= cnt_q[ch_q] + 8'd1;
    end
  end

  assign count_out_o = cnt_q[mon_sel_i];
`else
  assign count_out_o = 8'd0;
`endif

endmodule

// File: tb/tb_adex_neuron_array.sv
// tb/tb_adex_neuron_array.sv - scoreboard bench for adex_neuron_array (default parameters)
module tb_adex_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en_i;
  logic [N*W-1:0] current_i;
  logic [1:0]     mon_sel_i;
  logic [N-1:0]   spike_o;
  logic           aer_valid_o;
  logic [1:0]     aer_addr_o;
  logic [W-1:0]   state_o;
  logic [W-1:0]   w_out_o;
  logic [7:0]     count_out_o;

  adex_neuron_array dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .current_i   (current_i),
    .mon_sel_i   (mon_sel_i),
    .spike_o     (spike_o),
    .aer_valid_o (aer_valid_o),
    .aer_addr_o  (aer_addr_o),
    .state_o     (state_o),
    .w_out_o     (w_out_o),
    .count_out_o (count_out_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] spk;
    logic [1:0] addr;
    logic [7:0] v;
    logic [7:0] w;
    logic       chk;
  } sb_t;

  sb_t sb_q[$];
  sb_t x;
  int  checks = 0;
  int  errors = 0;

  localparam int VTAB [10] = '{40, 75, 106, 133, 157, 185, 20, 20, 20, 43};
  localparam int WTAB [10] = '{0, 0, 0, 0, 0, 0, 16, 15, 15, 15};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en_i      = 1'b1;
    current_i = '0;
    mon_sel_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (spike_o !== 4'b0 || aer_valid_o !== 1'b0 || state_o !== 8'd0 || w_out_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_initial spike=%b aer_valid=%b state=%0d w=%0d want all 0", spike_o, aer_valid_o, state_o, w_out_o);
    end
    current_i[2*W +: W] = 8'd255;
    mon_sel_i = 2'd2;
    repeat (3) tick();
    checks++;
    if (spike_o !== 4'b0100 || state_o !== 8'd20) begin
      errors++;
      $display("FAIL reset_pre_spike spike=%b state=%0d want 0100/20", spike_o, state_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (spike_o !== 4'b0 || aer_valid_o !== 1'b0 || aer_addr_o !== 2'd0 ||
        state_o !== 8'd0 || w_out_o !== 8'd0 || count_out_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_async spike=%b aer_valid=%b addr=%0d state=%0d w=%0d cnt=%0d want all 0",
               spike_o, aer_valid_o, aer_addr_o, state_o, w_out_o, count_out_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_current();
    int seen;
    do_reset();
    seen = 0;
    repeat (64) begin
      tick();
      if (spike_o !== 4'b0 || aer_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL zero_no_spike spiking_cycles=%0d want 0", seen);
    end
    for (int m = 0; m < N; m++) begin
      mon_sel_i = m[1:0];
      #1;
      checks++;
      if (state_o !== 8'd0 || w_out_o !== 8'd0) begin
        errors++;
        $display("FAIL zero_ch%0d v=%0d w=%0d want 0/0", m, state_o, w_out_o);
      end
    end
  endtask

  task automatic test_integrate_refractory();
    do_reset();
    current_i[0 +: W] = 8'd40;
    mon_sel_i = 2'd0;
    for (int e = 0; e < 37; e++) begin
      if (e % 4 == 0)
        sb_q.push_back('{spk: (e / 4 == 6) ? 4'b0001 : 4'b0000, addr: 2'd0,
                         v: VTAB[e / 4][7:0], w: WTAB[e / 4][7:0], chk: 1'b1});
      else
        sb_q.push_back('{spk: 4'b0000, addr: 2'd0, v: 8'd0, w: 8'd0, chk: 1'b0});
    end
    for (int e = 1; sb_q.size() > 0; e++) begin
      tick();
      x = sb_q.pop_front();
      checks++;
      if (spike_o !== x.spk || aer_valid_o !== (x.spk != 4'b0)) begin
        errors++;
        $display("FAIL integ_spike edge=%0d spike=%b aer_valid=%b want %b", e, spike_o, aer_valid_o, x.spk);
      end
      if (x.spk != 4'b0) begin
        checks++;
        if (aer_addr_o !== x.addr) begin
          errors++;
          $display("FAIL integ_aer_addr edge=%0d addr=%0d want %0d", e, aer_addr_o, x.addr);
        end
      end
      if (x.chk) begin
        checks++;
        if (state_o !== x.v || w_out_o !== x.w) begin
          errors++;
          $display("FAIL integ_vw edge=%0d v=%0d w=%0d want %0d/%0d", e, state_o, w_out_o, x.v, x.w);
        end
      end
    end
  endtask

  task automatic test_strong_drive();
    do_reset();
    current_i[2*W +: W] = 8'd255;
    mon_sel_i = 2'd2;
    sb_q.push_back('{spk: 4'b0000, addr: 2'd0, v: 8'd0,  w: 8'd0,  chk: 1'b1});
    sb_q.push_back('{spk: 4'b0000, addr: 2'd0, v: 8'd0,  w: 8'd0,  chk: 1'b1});
    sb_q.push_back('{spk: 4'b0100, addr: 2'd2, v: 8'd20, w: 8'd16, chk: 1'b1});
    sb_q.push_back('{spk: 4'b0000, addr: 2'd0, v: 8'd20, w: 8'd16, chk: 1'b1});
    for (int e = 1; sb_q.size() > 0; e++) begin
      tick();
      x = sb_q.pop_front();
      checks++;
      if (spike_o !== x.spk || aer_valid_o !== (x.spk != 4'b0) || state_o !== x.v || w_out_o !== x.w) begin
        errors++;
        $display("FAIL strong edge=%0d spike=%b aer_valid=%b v=%0d w=%0d want %b/%0d/%0d",
                 e, spike_o, aer_valid_o, state_o, w_out_o, x.spk, x.v, x.w);
      end
      if (x.spk != 4'b0) begin
        checks++;
        if (aer_addr_o !== x.addr) begin
          errors++;
          $display("FAIL strong_aer_addr addr=%0d want %0d", aer_addr_o, x.addr);
        end
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    current_i[2*W +: W] = 8'd255;
    current_i[3*W +: W] = 8'd255;
    mon_sel_i = 2'd2;
    repeat (3) tick();
    checks++;
    if (spike_o !== 4'b0100) begin
      errors++;
      $display("FAIL freeze_pre spike=%b want 0100", spike_o);
    end
    en_i = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (spike_o !== 4'b0 || aer_valid_o !== 1'b0 || state_o !== 8'd20 || w_out_o !== 8'd16) begin
        errors++;
        $display("FAIL freeze_hold cyc=%0d spike=%b aer_valid=%b v=%0d w=%0d want 0/0/20/16",
                 e, spike_o, aer_valid_o, state_o, w_out_o);
      end
    end
    en_i = 1'b1;
    tick();
    checks++;
    if (spike_o !== 4'b1000 || aer_valid_o !== 1'b1 || aer_addr_o !== 2'd3 || w_out_o !== 8'd16) begin
      errors++;
      $display("FAIL freeze_resume spike=%b aer_valid=%b addr=%0d w2=%0d want 1000/1/3/16",
               spike_o, aer_valid_o, aer_addr_o, w_out_o);
    end
  endtask

  task automatic test_count();
    do_reset();
    current_i[1*W +: W] = 8'd255;
    mon_sel_i = 2'd1;
`ifdef ADEX_SPIKE_COUNT_EN
    repeat (400) tick();
    checks++;
    if (count_out_o === 8'd0 || count_out_o === 8'd255) begin
      errors++;
      $display("FAIL count_mid count=%0d want between 1 and 254", count_out_o);
    end
    repeat (7600) tick();
    checks++;
    if (count_out_o !== 8'd255) begin
      errors++;
      $display("FAIL count_sat count=%0d want 255", count_out_o);
    end
`else
    for (int k = 0; k < 2; k++) begin
      repeat (2000) tick();
      checks++;
      if (count_out_o !== 8'd0) begin
        errors++;
        $display("FAIL count_off k=%0d count=%0d want 0", k, count_out_o);
      end
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    en_i      = 1'b1;
    current_i = '0;
    mon_sel_i = '0;
    test_reset();
    test_zero_current();
    test_integrate_refractory();
    test_strong_drive();
    test_enable_freeze();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
